ecc_collect: RTL and testbench
==============================

ECC_COLLECT -- requirements
Module: ecc_collect

Interface
REQ-001 Parameter DATA_BITS, default 192, payload bits per frame; must be a multiple of BITS.
REQ-002 Parameter ECC_BITS, default 64, parity bits per frame (BCH T=8, m=8); must be a multiple of BITS.
REQ-003 Parameter BITS, default 8, width of one stream beat.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 ce  input  1  beat-enable from encoder; inputs are ignored when 0.
REQ-007 data_in  input  BITS  encoder output beat.
REQ-008 first  input  1  marks the first beat of a frame.
REQ-009 last  input  1  marks the final beat of a frame.
REQ-010 data_bits  input  1  beat carries payload.
REQ-011 ecc_bits  input  1  beat carries parity.
REQ-012 data_out  output  DATA_BITS  collected payload, first beat in MS byte.
REQ-013 ecc_out  output  ECC_BITS  collected parity, first parity beat in MS byte.
REQ-014 valid  output  1  one-cycle pulse: data_out/ecc_out hold a complete frame.
REQ-015 busy  output  1  high while a frame is being collected.
REQ-016 err  output  1  one-cycle pulse on framing error.

Function
REQ-017 Beat accepted only when ce=1 and exactly one of data_bits/ecc_bits is 1; other cycles leave all state unchanged.
REQ-018 Constants ND=DATA_BITS/BITS (24), NE=ECC_BITS/BITS (8); beat counter wide enough for max(ND,NE).
REQ-019 FSM states IDLE, DATA, ECC; reset state IDLE.
REQ-020 IDLE: accepted data beat with first=1 -> shift into payload shadow, count=1, go DATA; accepted beats without first ignored, no err.
REQ-021 DATA: each accepted data beat shifts left by BITS, new beat enters LS byte, count+1; after beat ND go ECC with count=0.
REQ-022 ECC: each accepted ecc beat shifts into parity shadow likewise; beat NE with last=1 -> copy shadows to data_out/ecc_out, valid=1 next cycle, go IDLE.
REQ-023 Latency: valid and updated data_out/ecc_out appear exactly 1 cycle after the final beat is accepted.
REQ-024 data_out/ecc_out change only on a completed frame; hold value otherwise, including across errors.
REQ-025 busy=1 in DATA and ECC, 0 in IDLE; it is 0 in the cycle valid is 1.
REQ-026 Error: ecc beat in DATA, data beat in ECC, last on any beat but ECC beat NE, or ECC beat NE without last -> err=1 next cycle, shadows discarded, go IDLE.
REQ-027 Error: first=1 on an accepted beat in DATA/ECC -> err=1 next cycle and the beat restarts a new frame (handled as REQ-020).
REQ-028 ND=1 or NE=1 boundaries: transitions on count reaching N apply identically (first and last may share one beat only when ND+NE=1, not required).
REQ-029 valid and err never both 1 in one cycle.

Reset
REQ-030 rst_n=0 at a clock edge -> state IDLE, count 0, shadows 0, data_out 0, ecc_out 0, valid 0, busy 0, err 0.
REQ-031 Reset mid-frame discards the partial frame; no valid or err produced for it.

Verification
REQ-032 Clean frame: 24 data beats of 192'h123456789ABCDEF0123456789ABCDEF0123456789ABCDEF1 MSB-first, then ecc beats A0..A7 with last on A7 -> 1 cycle later valid=1, data_out=that value, ecc_out=64'hA0A1A2A3A4A5A6A7, busy=0.
REQ-033 ce gaps: same frame with ce=0 inserted every 3rd cycle -> identical outputs, valid 1 cycle after A7 accepted.
REQ-034 Early parity: ecc beat after 10 data beats -> err pulse, state IDLE, data_out/ecc_out keep prior frame, no valid.
REQ-035 Restart: first=1 at data beat 5 of a frame, then full clean frame from that beat -> err pulse once, then valid with the new frame's values.
REQ-036 Missing last: ecc beat 8 with last=0 -> err pulse, no valid; following clean frame collected correctly.
REQ-037 Reset at data beat 12 -> all outputs 0, busy 0; subsequent clean frame yields valid with correct values.

Source files
------------

// File: rtl/ecc_collect.sv
// ecc_collect: gathers payload and parity beats from a BCH encoder stream
// into whole frames and presents them with a one-cycle valid pulse.
module ecc_collect #(
  parameter int DATA_BITS = 192,
  parameter int ECC_BITS  = 64,
  parameter int BITS      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [BITS-1:0]      data_in,
  input  logic                 first,
  input  logic                 last,
  input  logic                 data_bits,
  input  logic                 ecc_bits,
  output logic [DATA_BITS-1:0] data_out,
  output logic [ECC_BITS-1:0]  ecc_out,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam int ND   = DATA_BITS / BITS;
  localparam int NE   = ECC_BITS / BITS;
  localparam int NMAX = (ND > NE) ? ND : NE;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [CW-1:0] ND_C = CW'(ND);
  localparam logic [CW-1:0] NE_C = CW'(NE);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ECC
  } state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [DATA_BITS-1:0] dsh;
  logic [ECC_BITS-1:0]  esh;

  logic                 accept;
  logic                 is_d;
  logic                 is_e;
  logic [CW-1:0]        cnt_nx;
  logic [DATA_BITS-1:0] dsh_nx;
  logic [ECC_BITS-1:0]  esh_nx;

  assign accept = ce & (data_bits ^ ecc_bits);
  assign is_d   = data_bits;
  assign is_e   = ecc_bits;
  assign cnt_nx = count + 1'b1;
  assign dsh_nx = (dsh << BITS) | DATA_BITS'(data_in);
  assign esh_nx = (esh << BITS) | ECC_BITS'(data_in);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      dsh      <= '0;
      esh      <= '0;
      data_out <= '0;
      ecc_out  <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (accept) begin
        if (first) begin
          // A first beat always opens a new frame, aborting any open one.
          if (state != IDLE) err <= 1'b1;
          if (is_d && !last) begin
            dsh   <= DATA_BITS'(data_in);
            esh   <= '0;
            state <= (ND == 1) ? ECC : DATA;
            count <= (ND == 1) ? '0 : CW'(1);
          end else begin
            if (is_d) err <= 1'b1;
            state <= IDLE;
            count <= '0;
            dsh   <= '0;
            esh   <= '0;
          end
        end else begin
          unique case (state)
            IDLE: ;
            DATA: begin
              if (is_e || last) begin
                err   <= 1'b1;
                state <= IDLE;
                count <= '0;
                dsh   <= '0;
                esh   <= '0;
              end else if (cnt_nx == ND_C) begin
                dsh   <= dsh_nx;
                state <= ECC;
                count <= '0;
              end else begin
                dsh   <= dsh_nx;
                count <= cnt_nx;
              end
            end
            ECC: begin
              if (is_d || (last != (cnt_nx == NE_C))) begin
                err   <= 1'b1;
                state <= IDLE;
                count <= '0;
                dsh   <= '0;
                esh   <= '0;
              end else if (last) begin
                data_out <= dsh;
                ecc_out  <= esh_nx;
                valid    <= 1'b1;
                state    <= IDLE;
                count    <= '0;
                esh      <= esh_nx;
              end else begin
                esh   <= esh_nx;
                count <= cnt_nx;
              end
            end
            default: begin
              state <= IDLE;
              count <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ecc_collect.sv
// tb_ecc_collect: directed frames with hand-computed results for
// ecc_collect, covering clean, gapped, aborted and reset frames.
module tb_ecc_collect;

  logic         clk;
  logic         rst_n;
  logic         ce;
  logic [7:0]   data_in;
  logic         first;
  logic         last;
  logic         data_bits;
  logic         ecc_bits;
  logic [191:0] data_out;
  logic [63:0]  ecc_out;
  logic         valid;
  logic         busy;
  logic         err;

  int n_run;
  int n_fail;

  logic [191:0] d1;
  logic [63:0]  e1;
  logic [191:0] d2;
  logic [63:0]  e2;
  int           cyc;

  ecc_collect dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ce        (ce),
    .data_in   (data_in),
    .first     (first),
    .last      (last),
    .data_bits (data_bits),
    .ecc_bits  (ecc_bits),
    .data_out  (data_out),
    .ecc_out   (ecc_out),
    .valid     (valid),
    .busy      (busy),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [191:0] got,
                       input logic [191:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    ce        = 1'b0;
    data_in   = 8'h00;
    first     = 1'b0;
    last      = 1'b0;
    data_bits = 1'b0;
    ecc_bits  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit isd,
                      input bit f, input bit l);
    ce        = 1'b1;
    data_in   = b;
    data_bits = isd;
    ecc_bits  = !isd;
    first     = f;
    last      = l;
    @(negedge clk);
    idle_in();
  endtask

  task automatic gap(input bit gaps);
    if (gaps && (cyc % 3 == 2)) begin
      if (cyc % 2 == 0) begin
        ce = 1'b0; data_bits = 1'b1; first = 1'b1;
      end else begin
        ce = 1'b1; data_bits = 1'b1; ecc_bits = 1'b1;
        first = 1'b1; last = 1'b1;
      end
      data_in = 8'hEE;
      @(negedge clk);
      idle_in();
      cyc++;
    end
    cyc++;
  endtask

  task automatic partial(input logic [191:0] d, input int n);
    for (int i = 0; i < n; i++)
      send(d[191-8*i -: 8], 1'b1, i == 0, 1'b0);
  endtask

  task automatic frame(input logic [191:0] d, input logic [63:0] e,
                       input bit gaps, input bit bad_last,
                       input bit err_first);
    cyc = 0;
    for (int i = 0; i < 24; i++) begin
      gap(gaps);
      send(d[191-8*i -: 8], 1'b1, i == 0, 1'b0);
      if (i == 0) begin
        check("first_err", err, err_first);
        check("first_busy", busy, 1'b1);
      end
    end
    for (int i = 0; i < 8; i++) begin
      gap(gaps);
      send(e[63-8*i -: 8], 1'b0, 1'b0, (i == 7) && !bad_last);
    end
  endtask

  task automatic expect_done(input string tag, input logic [191:0] d,
                             input logic [63:0] e);
    check({tag, "_valid"}, valid, 1'b1);
    check({tag, "_data"}, data_out, d);
    check({tag, "_ecc"}, ecc_out, e);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    @(negedge clk);
    check({tag, "_vpulse"}, valid, 1'b0);
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    d1 = 192'h123456789ABCDEF0123456789ABCDEF0123456789ABCDEF1;
    e1 = 64'hA0A1A2A3A4A5A6A7;
    d2 = ~d1;
    e2 = 64'h5A4B3C2D1E0F1122;
    idle_in();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", data_out, '0);
    check("rst_ecc", ecc_out, '0);
    check("rst_valid", valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // beat without first in IDLE is ignored
    send(8'h55, 1'b1, 1'b0, 1'b0);
    check("idle_ign_err", err, 1'b0);
    check("idle_ign_busy", busy, 1'b0);

    frame(d1, e1, 1'b0, 1'b0, 1'b0);
    expect_done("clean", d1, e1);

    frame(d2, e2, 1'b0, 1'b0, 1'b0);
    expect_done("clean2", d2, e2);

    frame(d1, e1, 1'b1, 1'b0, 1'b0);
    expect_done("gaps", d1, e1);

    // parity arrives after only 10 payload beats
    partial(d2, 10);
    send(8'hA0, 1'b0, 1'b0, 1'b0);
    check("early_err", err, 1'b1);
    check("early_valid", valid, 1'b0);
    check("early_busy", busy, 1'b0);
    check("early_data", data_out, d1);
    check("early_ecc", ecc_out, e1);
    @(negedge clk);
    check("early_epulse", err, 1'b0);

    partial(d2, 5);
    frame(d2, e2, 1'b0, 1'b0, 1'b1);
    expect_done("restart", d2, e2);

    frame(d1, e1, 1'b0, 1'b1, 1'b0);
    check("nolast_err", err, 1'b1);
    check("nolast_valid", valid, 1'b0);
    check("nolast_busy", busy, 1'b0);
    check("nolast_data", data_out, d2);
    frame(d1, e1, 1'b0, 1'b0, 1'b0);
    expect_done("after_nolast", d1, e1);

    partial(d2, 12);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_data", data_out, '0);
    check("mrst_ecc", ecc_out, '0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_valid", valid, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mrst_err", err, 1'b0);
    frame(d2, e2, 1'b0, 1'b0, 1'b0);
    expect_done("after_rst", d2, e2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
